// File: rtl/matrix_scroll_ctrl.sv
// Frame sequencer for the 8x8 LED strip matrix: renders scrolling a-z text from a
// message buffer and streams one pixel per accepted valid/ready handshake.
module matrix_scroll_ctrl #(
    parameter int MSG_LEN    = 16,
    parameter int SCROLL_DIV = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          wr_en,
    input  logic [$clog2(MSG_LEN)-1:0]    wr_addr,
    input  logic [4:0]                    wr_data,
    input  logic [$clog2(MSG_LEN):0]      msg_len,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic                          pix_on,
    output logic [5:0]                    pix_idx,
    output logic                          pix_last,
    output logic                          busy,
    output logic [$clog2(8*MSG_LEN)-1:0]  offset
);
    localparam int AW = $clog2(MSG_LEN);
    localparam int OW = AW + 3;
    localparam int CW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

    state_t        state, next_state;
    logic [4:0]    msg_buf [MSG_LEN];
    logic [AW:0]   len_q;
    logic [CW-1:0] frame_cnt;

    logic [AW:0]   load_len;
    logic [OW-1:0] load_off;
    logic [5:0]    calc_idx;
    logic [OW-1:0] calc_off;
    logic [AW:0]   calc_len;
    logic [OW:0]   calc_span;
    logic [OW:0]   vc_sum;
    logic [OW-1:0] vc;
    logic [4:0]    calc_code;
    logic [63:0]   calc_glyph;
    logic [7:0]    calc_row;
    logic          calc_on;
    logic [OW:0]   step_sum;
    logic [OW-1:0] step_off;
    logic          last_accept;
    logic          do_load, do_step, do_done;

    // Row 0 is the top byte; bit n of a row byte is font column n.
    function automatic logic [63:0] glyph(input logic [4:0] code);
        case (code)
            5'd0:    glyph = 64'h00001E303E336E00;
            5'd1:    glyph = 64'h0706063E66663B00;
            5'd2:    glyph = 64'h00001E3303331E00;
            5'd3:    glyph = 64'h3830303E33336E00;
            5'd4:    glyph = 64'h00001E333F031E00;
            5'd5:    glyph = 64'h1C36060F06060F00;
            5'd6:    glyph = 64'h00006E33333E301F;
            5'd7:    glyph = 64'h0706366E66666700;
            5'd8:    glyph = 64'h0C000E0C0C0C1E00;
            5'd9:    glyph = 64'h300030303033331E;
            5'd10:   glyph = 64'h070666361E366700;
            5'd11:   glyph = 64'h0E0C0C0C0C0C1E00;
            5'd12:   glyph = 64'h0000337F7F6B6300;
            5'd13:   glyph = 64'h00001F3333333300;
            5'd14:   glyph = 64'h00001E3333331E00;
            5'd15:   glyph = 64'h00003B66663E060F;
            5'd16:   glyph = 64'h00006E33333E3078;
            5'd17:   glyph = 64'h00003B6E66060F00;
            5'd18:   glyph = 64'h00003E031E301F00;
            5'd19:   glyph = 64'h080C3E0C0C2C1800;
            5'd20:   glyph = 64'h0000333333336E00;
            5'd21:   glyph = 64'h00003333331E0C00;
            5'd22:   glyph = 64'h0000636B7F7F3600;
            5'd23:   glyph = 64'h000063361C366300;
            5'd24:   glyph = 64'h00003333333E301F;
            5'd25:   glyph = 64'h00003F190C263F00;
            default: glyph = 64'h0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (en) next_state = LOAD;
            LOAD:    next_state = STREAM;
            STREAM:  if (last_accept) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        last_accept = (state == STREAM) && pix_ready && (pix_idx == 6'd63);
        do_load     = (state == LOAD);
        do_step     = (state == STREAM) && pix_ready && (pix_idx != 6'd63);
        do_done     = (state == DONE);
    end

    // LOAD renders pixel 0 with the freshly clamped length and offset, STREAM renders idx+1.
    always_comb begin
        load_len = (msg_len > (AW+1)'(MSG_LEN)) ? (AW+1)'(MSG_LEN) : msg_len;
        load_off = offset;
        if (load_len == '0 || {1'b0, offset} >= {load_len, 3'b000})
            load_off = '0;

        if (state == LOAD) begin
            calc_idx = 6'd0;
            calc_off = load_off;
            calc_len = load_len;
        end else begin
            calc_idx = pix_idx + 6'd1;
            calc_off = offset;
            calc_len = len_q;
        end

        // offset < span and span >= 8, so one conditional subtract is a full modulo.
        calc_span = {calc_len, 3'b000};
        vc_sum    = {1'b0, calc_off} + (OW+1)'(calc_idx[2:0]);
        if (vc_sum >= calc_span)
            vc_sum = vc_sum - calc_span;
        vc         = vc_sum[OW-1:0];
        calc_code  = msg_buf[vc[OW-1:3]];
        calc_glyph = glyph(calc_code);
        calc_row   = calc_glyph[{~calc_idx[5:3], 3'b000} +: 8];
        calc_on    = (calc_len != '0) && calc_row[vc[2:0]];

        step_sum = {1'b0, offset} + (OW+1)'(1);
        step_off = step_sum[OW-1:0];
        if (len_q == '0 || step_sum >= {len_q, 3'b000})
            step_off = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < MSG_LEN; i++)
                msg_buf[i] <= 5'd31;
        end else if (wr_en) begin
            msg_buf[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pix_valid <= 1'b0;
            pix_on    <= 1'b0;
            pix_idx   <= 6'd0;
            pix_last  <= 1'b0;
            busy      <= 1'b0;
            offset    <= '0;
            frame_cnt <= '0;
            len_q     <= '0;
        end else begin
            busy <= (next_state != IDLE);
            if (do_load) begin
                len_q     <= load_len;
                offset    <= load_off;
                pix_idx   <= 6'd0;
                pix_on    <= calc_on;
                pix_last  <= 1'b0;
                pix_valid <= 1'b1;
            end
            if (do_step) begin
                pix_idx  <= calc_idx;
                pix_on   <= calc_on;
                pix_last <= (calc_idx == 6'd63);
            end
            if (last_accept) begin
                pix_valid <= 1'b0;
                pix_last  <= 1'b0;
            end
            if (do_done) begin
                if (frame_cnt == CW'(SCROLL_DIV - 1)) begin
                    frame_cnt <= '0;
                    offset    <= step_off;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/matrix_scroll_ctrl.md
# matrix_scroll_ctrl

Frame sequencer for the 8x8 (64-LED) strip matrix. It holds a message buffer of letter codes and renders one 64-pixel frame at a time from an internal 26-glyph a–z font ROM. It streams the frame's pixel on/off bits to the strip serializer over a valid/ready handshake, and advances a horizontal scroll offset every `SCROLL_DIV` frames. It sits between the host/io_in write path and the serializer that produces the start frame, 32-bit LED words and end frame.

## Interface
- `MSG_LEN`, 16: message buffer depth in characters (power of 2, 2..32).
- `SCROLL_DIV`, 8: completed frames per one-column scroll step (>=1).
- `clk`  in  1  single clock; all state changes on posedge.
- `reset`  in  1  synchronous, active-low; sampled on posedge `clk`.
- `en`  in  1  enables frame generation; sampled only in IDLE.
- `wr_en`  in  1  message buffer write strobe.
- `wr_addr`  in  clog2(MSG_LEN)  buffer entry to write.
- `wr_data`  in  5  letter code: 0..25 = a..z; 26..31 = blank glyph.
- `msg_len`  in  clog2(MSG_LEN)+1  active characters; latched at frame start.
- `pix_valid`  out  1  pixel presented.
- `pix_ready`  in  1  serializer accepts pixel.
- `pix_on`  out  1  pixel lit.
- `pix_idx`  out  6  pixel index = row*8 + col.
- `pix_last`  out  1  high with pixel 63.
- `busy`  out  1  high in any state other than IDLE.
- `offset`  out  clog2(8*MSG_LEN)  current scroll column offset.

## Operation
- FSM states: IDLE, LOAD, STREAM, DONE.
- IDLE to LOAD when `en`=1.
- LOAD (1 cycle):
  - Latch `len_q` = min(`msg_len`, MSG_LEN).
  - If `len_q`=0 or `offset` >= 8*`len_q`, clear `offset` to 0.
  - Compute pixel 0 into the output registers.
- STREAM:
  - `pix_valid`=1.
  - On `pix_valid`&&`pix_ready` with `pix_idx`=63, go to DONE.
  - Otherwise increment `pix_idx` and register the next pixel.
- DONE (1 cycle):
  - `frame_cnt`++.
  - If `frame_cnt` was SCROLL_DIV-1: clear it, and set `offset` = (`offset`+1) mod 8*`len_q`.
  - Then go to IDLE.
- Pixel rendering, with r = idx[5:3], c = idx[2:0]:
  - Virtual column vc = (`offset` + c) mod 8*`len_q`.
  - code = buf[vc>>3]; font column fc = vc[2:0].
  - `pix_on` = bit fc of glyph row r, where row 0 is the most significant byte of the 64-bit glyph word.
  - Blank code, or `len_q`=0, gives `pix_on`=0.
- Font ROM: 26 x 64-bit constants, standard 8x8 lowercase set. 'a' = 64'h00001E303E336E00.
- Writes:
  - Accepted in any state.
  - The entry updates at the posedge where `wr_en`=1; pixels computed from the following cycle onward see the new value.
  - An already-registered pixel is unaffected.
  - Tearing on mid-frame writes is permitted.
- `en` dropping mid-frame never truncates a frame; the FSM returns to IDLE only after DONE.
- Modulo arithmetic is width-safe: 8*MSG_LEN must fit in the `offset` width + 1.

## Timing
- Reset values (next posedge with `reset`=0):
  - State = IDLE.
  - `pix_valid`, `pix_on`, `pix_idx`, `pix_last`, `busy`, `offset`, `frame_cnt` = 0; `len_q` = 0.
  - All buffer entries = 31 (blank).
- Reset wins over `wr_en` and over any handshake in the same cycle. Reset mid-STREAM aborts the frame immediately.
- Latency: `en` high in IDLE at edge N gives LOAD at N+1; `pix_valid` is first high after edge N+2.
- Throughput is 1 pixel/cycle while `pix_ready`=1. With `en` held and ready always high, the frame period is 67 cycles (LOAD + 64 + DONE + IDLE).
- Backpressure: while `pix_valid`=1 and `pix_ready`=0, `pix_on`, `pix_idx` and `pix_last` hold stable.
- `pix_valid` never drops between pixel 0 and the accepted pixel 63.
- `busy` is registered, high from LOAD through DONE inclusive.

## Test plan
- Reset with garbage stimulus applied, then release → all outputs 0; a frame with `msg_len`=1 renders all 64 `pix_on`=0 (buffer is blank).
- Write buf[0]=0 ('a'), `msg_len`=1, `en`=1, ready held 1:
  - Lit pixels are exactly {17,18,19,20, 28,29, 33,34,35,36,37, 40,41,44,45, 49,50,51,53,54}.
  - `pix_last` is high only at idx 63.
  - The next frame's pixel 0 appears 3 cycles after pixel 63 is accepted.
- SCROLL_DIV=2, `msg_len`=2, buf={0, 31}:
  - After 2 frames `offset`=1, and row 2 is lit at idx 16..19.
  - After 32 frames `offset` wraps to 0.
- Random `pix_ready` deassertion (e.g. low 3 cycles at idx 10) → outputs stable while stalled; the pixel sequence is identical to the no-stall frame.
- Drop `en` at idx 30 → the frame completes through idx 63 and DONE, then the FSM stays in IDLE with `busy`=0.
- `msg_len` changes from 4 to 1 while `offset`=20 → the next LOAD clears `offset` to 0. `msg_len`=0 → a blank frame, and `offset` stays 0.
